serial_pattern_gen: RTL and testbench

Parametrised serial bit-pattern generator for the counters/detectors family. It holds a programmable pattern of 1..MAX_LEN bits and shifts it out one bit per clock, MSB-first or LSB-first. It runs in one-shot or repeat mode, with an optional idle gap between repeated frames. Typical use is as the stimulus source feeding the sequence detectors and counters.

---
 rtl/serial_pattern_gen_if.sv | 35 +++
 rtl/serial_pattern_gen.sv | 163 ++++++++++++++++
 tb/tb_serial_pattern_gen.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pattern_gen_if.sv
// Control/status bundle for serial_pattern_gen: pattern programming and run
// control toward the generator, serial stream and status back.
interface serial_pattern_gen_if #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6,
    parameter int GAP_W   = 4
);
    logic               load;
    logic [MAX_LEN-1:0] pattern_in;
    logic [LEN_W-1:0]   len_in;
    logic [GAP_W-1:0]   gap_in;
    logic               start;
    logic               stop;
    logic               abort;
    logic               repeat_en;
    logic               lsb_first;

    logic               out;
    logic               valid;
    logic               frame_start;
    logic [LEN_W-1:0]   bit_idx;
    logic               busy;
    logic               done;
    logic [15:0]        frame_cnt;

    modport master (
        output load, pattern_in, len_in, gap_in, start, stop, abort, repeat_en, lsb_first,
        input  out, valid, frame_start, bit_idx, busy, done, frame_cnt
    );

    modport slave (
        input  load, pattern_in, len_in, gap_in, start, stop, abort, repeat_en, lsb_first,
        output out, valid, frame_start, bit_idx, busy, done, frame_cnt
    );
endinterface

// File: rtl/serial_pattern_gen.sv
// Programmable serial bit-pattern generator: shifts out 1..MAX_LEN bits MSB- or
// LSB-first, one-shot or repeating with an optional idle gap between frames.
module serial_pattern_gen #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6,
    parameter int GAP_W   = 4
) (
    input logic                 clk,
    input logic                 reset,
    serial_pattern_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    state_t             state;
    logic [MAX_LEN-1:0] pat_reg;
    logic [LEN_W-1:0]   len_reg;
    logic [GAP_W-1:0]   gap_reg;
    logic [GAP_W-1:0]   gap_cnt;
    logic               rep_reg;
    logic               lsb_reg;
    logic               stop_flag;

    logic               out_r;
    logic               valid_r;
    logic               frame_start_r;
    logic               busy_r;
    logic               done_r;
    logic [LEN_W-1:0]   bit_idx_r;
    logic [15:0]        frame_cnt_r;

    logic [LEN_W-1:0]   len_clamp;
    logic [LEN_W-1:0]   start_len;
    logic [MAX_LEN-1:0] start_pat;
    logic [LEN_W-1:0]   next_idx;
    logic               last_bit;
    logic               halt;

    // Bit k of the frame in emission order.
    function automatic logic pick(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] len,
                                  input logic [LEN_W-1:0] k, input logic lsb);
        logic [LEN_W-1:0] pos;
        pos = lsb ? k : len - k - LEN_W'(1);
        return |(p & (MAX_LEN'(1) << pos));
    endfunction

    // A start on the same edge as load must see the freshly loaded values.
    assign len_clamp = (bus.len_in > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len_in;
    assign start_len = bus.load ? len_clamp : len_reg;
    assign start_pat = bus.load ? bus.pattern_in : pat_reg;
    assign next_idx  = bit_idx_r + LEN_W'(1);
    assign last_bit  = (bit_idx_r == len_reg - LEN_W'(1));
    assign halt      = stop_flag | bus.stop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pat_reg       <= '0;
            len_reg       <= LEN_W'(MAX_LEN);
            gap_reg       <= '0;
            gap_cnt       <= '0;
            rep_reg       <= 1'b0;
            lsb_reg       <= 1'b0;
            stop_flag     <= 1'b0;
            out_r         <= 1'b0;
            valid_r       <= 1'b0;
            frame_start_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            bit_idx_r     <= '0;
            frame_cnt_r   <= '0;
        end else begin
            done_r        <= 1'b0;
            frame_start_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        pat_reg <= bus.pattern_in;
                        len_reg <= len_clamp;
                        gap_reg <= bus.gap_in;
                    end
                    if (bus.start && start_len != '0) begin
                        rep_reg       <= bus.repeat_en;
                        lsb_reg       <= bus.lsb_first;
                        stop_flag     <= 1'b0;
                        frame_cnt_r   <= '0;
                        state         <= RUN;
                        busy_r        <= 1'b1;
                        valid_r       <= 1'b1;
                        frame_start_r <= 1'b1;
                        bit_idx_r     <= '0;
                        out_r         <= pick(start_pat, start_len, '0, bus.lsb_first);
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state     <= IDLE;
                        busy_r    <= 1'b0;
                        valid_r   <= 1'b0;
                        out_r     <= 1'b0;
                        bit_idx_r <= '0;
                        stop_flag <= 1'b0;
                    end else if (last_bit) begin
                        frame_cnt_r <= frame_cnt_r + 16'd1;
                        bit_idx_r   <= '0;
                        if (halt || !rep_reg) begin
                            state     <= IDLE;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                            valid_r   <= 1'b0;
                            out_r     <= 1'b0;
                            stop_flag <= 1'b0;
                        end else if (gap_reg == '0) begin
                            frame_start_r <= 1'b1;
                            out_r         <= pick(pat_reg, len_reg, '0, lsb_reg);
                        end else begin
                            state   <= GAP;
                            gap_cnt <= gap_reg - GAP_W'(1);
                            valid_r <= 1'b0;
                            out_r   <= 1'b0;
                        end
                    end else begin
                        if (bus.stop) stop_flag <= 1'b1;
                        bit_idx_r <= next_idx;
                        out_r     <= pick(pat_reg, len_reg, next_idx, lsb_reg);
                    end
                end
                GAP: begin
                    if (bus.abort) begin
                        state     <= IDLE;
                        busy_r    <= 1'b0;
                        stop_flag <= 1'b0;
                    end else if (halt) begin
                        // No further frame once stop has been seen.
                        state     <= IDLE;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        stop_flag <= 1'b0;
                    end else if (gap_cnt == '0) begin
                        state         <= RUN;
                        valid_r       <= 1'b1;
                        frame_start_r <= 1'b1;
                        bit_idx_r     <= '0;
                        out_r         <= pick(pat_reg, len_reg, '0, lsb_reg);
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out         = out_r;
    assign bus.valid       = valid_r;
    assign bus.frame_start = frame_start_r;
    assign bus.bit_idx     = bit_idx_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.frame_cnt   = frame_cnt_r;
endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: hand-derived vector table, corner sequences and
// randomized runs against a cycle-position reference model.
module tb_serial_pattern_gen;
    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;
    localparam int GAP_W   = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    serial_pattern_gen_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .GAP_W(GAP_W)) bus ();
    serial_pattern_gen #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .GAP_W(GAP_W)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // busy, valid, out, frame_start, done, bit_idx, frame_cnt
    logic [26:0] act;
    assign act = {bus.busy, bus.valid, bus.out, bus.frame_start, bus.done, bus.bit_idx, bus.frame_cnt};

    // Shadow of what the generator should hold in its pattern registers.
    logic [MAX_LEN-1:0] m_pat = '0;
    int m_len = MAX_LEN;
    int m_gap = 0;
    int m_fc  = 0;

    typedef struct {
        logic [MAX_LEN-1:0] pat;
        int len, gap;
        bit rep, lsb;
        int stop_at, abort_at, ncyc;
        logic [47:0] e_busy, e_valid, e_out, e_fs, e_done;
        int e_fc;
    } vec_t;
    vec_t tbl [7];

    task automatic check(input string name, input logic [63:0] a, input logic [63:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    function automatic vec_t mk(input logic [MAX_LEN-1:0] pat, input int len, input int gap,
                                input bit rep, input bit lsb, input int stop_at, input int abort_at,
                                input int ncyc, input logic [47:0] eb, input logic [47:0] ev,
                                input logic [47:0] eo, input logic [47:0] ef, input logic [47:0] ed,
                                input int efc);
        vec_t v;
        v.pat = pat; v.len = len; v.gap = gap; v.rep = rep; v.lsb = lsb;
        v.stop_at = stop_at; v.abort_at = abort_at; v.ncyc = ncyc;
        v.e_busy = eb; v.e_valid = ev; v.e_out = eo; v.e_fs = ef; v.e_done = ed; v.e_fc = efc;
        return v;
    endfunction

    // First idle cycle after the start edge (cycle 0 = first bit).
    function automatic int run_end(input bit rep, input int stop_at, input int abort_at, output bit aborted);
        int p, d;
        p = m_len + m_gap;
        d = rep ? (1 << 30) : m_len;
        if (rep && stop_at >= 0)
            d = (stop_at % p < m_len) ? (stop_at / p) * p + m_len : stop_at + 1;
        aborted = 1'b0;
        if (abort_at >= 0 && abort_at < d) begin
            d = abort_at + 1;
            aborted = 1'b1;
        end
        return d;
    endfunction

    // Outputs at cycle t: frames tile time with period len+gap, the run ends at d.
    function automatic logic [26:0] model(input int t, input bit started, input bit rep, input bit lsb,
                                          input int stop_at, input int abort_at);
        int p, d, lim, n, pos;
        bit aborted, b;
        if (!started) return {11'b0, 16'(m_fc)};
        p   = m_len + m_gap;
        d   = run_end(rep, stop_at, abort_at, aborted);
        lim = aborted ? d - 1 : d;
        if (t < lim) lim = t;
        n = (lim >= m_len) ? (lim - m_len) / p + 1 : 0;
        if (t < d) begin
            pos = t % p;
            if (pos < m_len) begin
                b = lsb ? m_pat[pos] : m_pat[m_len - 1 - pos];
                return {1'b1, 1'b1, b, (pos == 0), 1'b0, LEN_W'(pos), 16'(n)};
            end
            return {1'b1, 4'b0, LEN_W'(0), 16'(n)};
        end
        return {4'b0, (t == d) && !aborted, LEN_W'(0), 16'(n)};
    endfunction

    task automatic run(input bit do_load, input logic [MAX_LEN-1:0] pat, input int len_in, input int gap,
                       input bit rep, input bit lsb, input int stop_at, input int abort_at,
                       input int junk_at, input int ncyc, input string tag);
        logic [26:0] e;
        bit started, aborted;
        int n;
        if (do_load) begin
            m_pat = pat;
            m_len = (len_in > MAX_LEN) ? MAX_LEN : len_in;
            m_gap = gap;
        end
        started = (m_len != 0);
        n = ncyc;
        if (n < 0) n = started ? run_end(rep, stop_at, abort_at, aborted) + 2 : 4;
        bus.load = do_load; bus.pattern_in = pat; bus.len_in = LEN_W'(len_in); bus.gap_in = GAP_W'(gap);
        bus.start = 1'b1; bus.repeat_en = rep; bus.lsb_first = lsb;
        @(posedge clk); #1;
        bus.load = 1'b0; bus.start = 1'b0;
        bus.repeat_en = ~rep; bus.lsb_first = ~lsb;
        for (int t = 0; t < n; t++) begin
            bus.stop  = (t == stop_at);
            bus.abort = (t == abort_at);
            if (t == junk_at) begin
                bus.load = 1'b1; bus.start = 1'b1; bus.pattern_in = ~pat;
                bus.len_in = LEN_W'(3); bus.gap_in = '1;
            end
            @(negedge clk);
            e = model(t, started, rep, lsb, stop_at, abort_at);
            check(tag, act, e);
            @(posedge clk); #1;
            bus.load = 1'b0; bus.start = 1'b0;
        end
        bus.stop = 1'b0; bus.abort = 1'b0;
        e = model(n, started, rep, lsb, stop_at, abort_at);
        m_fc = int'(e[15:0]);
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        logic [4:0] e;
        bus.load = 1'b1; bus.pattern_in = v.pat; bus.len_in = LEN_W'(v.len); bus.gap_in = GAP_W'(v.gap);
        bus.start = 1'b1; bus.repeat_en = v.rep; bus.lsb_first = v.lsb;
        @(posedge clk); #1;
        bus.load = 1'b0; bus.start = 1'b0;
        bus.repeat_en = ~v.rep; bus.lsb_first = ~v.lsb;
        for (int t = 0; t < v.ncyc; t++) begin
            bus.stop  = (t == v.stop_at);
            bus.abort = (t == v.abort_at);
            @(negedge clk);
            e = {v.e_busy[t], v.e_valid[t], v.e_out[t], v.e_fs[t], v.e_done[t]};
            check($sformatf("tbl%0d_c%0d", idx, t),
                  64'({bus.busy, bus.valid, bus.out, bus.frame_start, bus.done}), 64'(e));
            @(posedge clk); #1;
        end
        bus.stop = 1'b0; bus.abort = 1'b0;
        @(negedge clk);
        check($sformatf("tbl%0d_frame_cnt", idx), 64'(bus.frame_cnt), 64'(v.e_fc));
        m_pat = v.pat;
        m_len = (v.len > MAX_LEN) ? MAX_LEN : v.len;
        m_gap = v.gap;
        m_fc  = v.e_fc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
        $fatal(1);
    end

    initial begin
        logic [MAX_LEN-1:0] pat;
        int lin, lenc, gap, p, sa, ab;
        bit rep, lsb;

        tbl[0] = mk(32'b10011, 5, 0, 0, 0, -1, -1, 7, 48'h1F, 48'h1F, 48'h19, 48'h1, 48'h20, 1);
        tbl[1] = mk(32'b10011, 5, 0, 0, 1, -1, -1, 7, 48'h1F, 48'h1F, 48'h13, 48'h1, 48'h20, 1);
        tbl[2] = mk(32'b101, 3, 2, 1, 0, 6, -1, 10, 48'hFF, 48'hE7, 48'hA5, 48'h21, 48'h100, 2);
        tbl[3] = mk(32'b1100, 4, 0, 1, 0, -1, 6, 10, 48'h7F, 48'h7F, 48'h33, 48'h11, 48'h0, 1);
        tbl[4] = mk(32'b1, 1, 0, 1, 0, -1, 3, 6, 48'hF, 48'hF, 48'hF, 48'hF, 48'h0, 3);
        tbl[5] = mk(32'h8000_0001, 40, 0, 0, 0, -1, -1, 35, 48'hFFFF_FFFF, 48'hFFFF_FFFF,
                    48'h8000_0001, 48'h1, 48'h1_0000_0000, 1);
        tbl[6] = mk(32'hFFFF_FFFF, 0, 0, 0, 0, -1, -1, 4, 48'h0, 48'h0, 48'h0, 48'h0, 48'h0, 1);

        bus.load = 1'b0; bus.pattern_in = '0; bus.len_in = '0; bus.gap_in = '0; bus.start = 1'b0;
        bus.stop = 1'b0; bus.abort = 1'b0; bus.repeat_en = 1'b0; bus.lsb_first = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_state", 64'(act), 64'd0);

        // Untouched registers after reset: all-zero pattern of MAX_LEN bits.
        run(0, '0, 0, 0, 0, 0, -1, -1, -1, -1, "default_regs");

        for (int i = 0; i < 7; i++) apply_vec(tbl[i], i);

        // Start accepted in the done cycle of the previous run.
        run(1, 32'b110, 3, 0, 0, 1, -1, -1, -1, 3, "restart_a");
        run(0, 32'b110, 3, 0, 0, 0, -1, -1, -1, -1, "restart_b");

        // load/start while busy must not disturb the frame or the stored pattern.
        run(1, 32'h0000_00A5, 8, 0, 0, 0, -1, -1, 2, -1, "busy_load");
        run(0, 32'h0, 0, 0, 0, 1, -1, -1, -1, -1, "after_busy_load");

        // Stop landing in the gap ends the run without another frame.
        run(1, 32'b1011, 4, 5, 1, 0, 6, -1, -1, -1, "stop_in_gap");
        run(1, 32'b0110, 4, 3, 1, 1, 4, -1, -1, -1, "stop_last_bit");

        // Reset mid-frame clears outputs and pattern registers.
        run(1, '1, 10, 0, 1, 0, -1, -1, -1, 3, "pre_reset");
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_mid", 64'(act), 64'd0);
        m_pat = '0; m_len = MAX_LEN; m_gap = 0; m_fc = 0;
        run(0, '0, 0, 0, 0, 1, -1, -1, -1, -1, "after_reset");

        for (int r = 0; r < 40; r++) begin
            pat  = MAX_LEN'($urandom);
            lin  = $urandom_range(1, MAX_LEN);
            if (r % 10 == 7) lin = $urandom_range(MAX_LEN + 1, 63);
            lenc = (lin > MAX_LEN) ? MAX_LEN : lin;
            gap  = $urandom_range(0, 15);
            rep  = 1'($urandom_range(0, 1));
            lsb  = 1'($urandom_range(0, 1));
            p    = lenc + gap;
            sa = -1; ab = -1;
            if ($urandom_range(0, 3) == 0) ab = $urandom_range(0, 2 * p);
            if (rep && (ab < 0 || $urandom_range(0, 1) == 1)) sa = $urandom_range(0, 3 * p);
            if (!rep && $urandom_range(0, 1) == 1) sa = $urandom_range(0, lenc - 1);
            run(1, pat, lin, gap, rep, lsb, sa, ab, -1, -1, $sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
